pe2_sched: RTL and testbench

// - Stage/butterfly sequencer for the PE2 add/sub unit, covering four operations: K-NTT, K-INTT, D-NTT and D-INTT.
// - Latches the operation when start is accepted and drives the PE2 mode pins (KD_mode, sel_0, sel_1).
// - Issues one butterfly pair per cycle, with a read index and stage number, to the coefficient memory.
// - Produces a write-back strobe and index aligned to the PE2 output latency of the selected path.
// - Drains the pipeline between stages so no read-after-write hazard reaches memory.

---
 rtl/pe2_sched.sv | 154 +++++++++++++++
 tb/tb_pe2_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe2_sched.sv
// rtl/pe2_sched.sv - PE2 stage/butterfly sequencer: mode pins, pair issue, latency-matched write-back
module pe2_sched #(
  parameter int PAIRS     = 128,
  parameter int STAGES_K  = 7,
  parameter int STAGES_D  = 8,
  parameter int LAT_NTT   = 1,
  parameter int LAT_KINTT = 2,
  parameter int LAT_DINTT = 8,
  parameter int IW        = (PAIRS > 1) ? $clog2(PAIRS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic          stall,
  output logic          KD_mode,
  output logic          sel_0,
  output logic          sel_1,
  output logic          rd_valid,
  output logic [IW-1:0] rd_idx,
  output logic [3:0]    stage,
  output logic          wb_valid,
  output logic [IW-1:0] wb_idx,
  output logic          busy,
  output logic          done
);

  localparam int LW = $clog2(LAT_DINTT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      stage_q, stage_d;
  logic [1:0]      op_q;
  logic            kd_q, s0_q, s1_q;
  logic [LAT_DINTT-1:0] dlv_q;
  logic [IW-1:0]   dli_q [LAT_DINTT];

  logic            accept;
  logic            pending;
  logic [LW-1:0]   lat;
  logic [3:0]      last_stage;
  logic            wb_v;
  logic [IW-1:0]   wb_i;

  always_comb begin
    lat = op_q[0] ? (op_q[1] ? LW'(LAT_DINTT) : LW'(LAT_KINTT)) : LW'(LAT_NTT);
    last_stage = op_q[1] ? 4'(STAGES_D - 1) : 4'(STAGES_K - 1);
  end

  // Only slots younger than the tap matter; older entries never reach wb.
  always_comb begin
    pending = 1'b0;
    wb_v    = 1'b0;
    wb_i    = '0;
    for (int i = 0; i < LAT_DINTT; i++) begin
      if (LW'(i) < lat) pending = pending | dlv_q[i];
      if (LW'(i + 1) == lat) begin
        wb_v = dlv_q[i];
        wb_i = dli_q[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stage_d  = stage_q;
    accept   = 1'b0;
    rd_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          idx_d   = '0;
          stage_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (!stall) begin
          rd_valid = 1'b1;
          if (idx_q == IW'(PAIRS - 1)) begin
            idx_d   = '0;
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!pending) begin
          if (stage_q < last_stage) begin
            stage_d = stage_q + 4'd1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        stage_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      stage_q <= '0;
      op_q    <= '0;
      kd_q    <= 1'b0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      dlv_q   <= '0;
      for (int i = 0; i < LAT_DINTT; i++) dli_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      if (accept) begin
        op_q <= op;
        kd_q <= op[1];
        s0_q <= ~op[1] & ~op[0];
        s1_q <= op[0];
      end
      // Flush leftovers of a previous op so a longer tap cannot pick them up.
      for (int i = LAT_DINTT - 1; i > 0; i--) begin
        dlv_q[i] <= accept ? 1'b0 : dlv_q[i-1];
        dli_q[i] <= dli_q[i-1];
      end
      dlv_q[0] <= rd_valid;
      dli_q[0] <= idx_q;
    end
  end

  assign KD_mode  = kd_q;
  assign sel_0    = s0_q;
  assign sel_1    = s1_q;
  assign rd_idx   = idx_q;
  assign stage    = stage_q;
  assign wb_valid = wb_v;
  assign wb_idx   = wb_i;

endmodule

// File: tb/tb_pe2_sched.sv
// tb/tb_pe2_sched.sv - directed table-driven bench for pe2_sched (PAIRS=4, 2 stages each)
module tb_pe2_sched;

  localparam int PAIRS = 4;
  localparam int IW    = 2;

  logic          clk = 1'b0;
  logic          rst, start, stall;
  logic [1:0]    op;
  logic          KD_mode, sel_0, sel_1, rd_valid, wb_valid, busy, done;
  logic [IW-1:0] rd_idx, wb_idx;
  logic [3:0]    stage;

  always #5 clk = ~clk;

  pe2_sched #(
    .PAIRS(PAIRS), .STAGES_K(2), .STAGES_D(2),
    .LAT_NTT(1), .LAT_KINTT(2), .LAT_DINTT(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .stall(stall),
    .KD_mode(KD_mode), .sel_0(sel_0), .sel_1(sel_1),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .stage(stage),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .busy(busy), .done(done)
  );

  typedef struct {
    logic [1:0] op;
    int         lat;
    int         kd, s0, s1;
    int         restart_at;
    logic [1:0] restart_op;
  } vec_t;

  vec_t vecs [5];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   done_c, per, s, o;
  int   e_rd, e_ri, e_wb, e_wi, e_st, e_busy, e_done;
  int   nrd, nwb, n_wb_seen, n_done_seen, n_busy_seen;
  int   rdc [8], rdi [8], wbc [8], wbi [8];
  int   exp_rdc [4] = '{1, 2, 6, 7};
  int   exp_wbc [4] = '{3, 4, 8, 9};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_op(input logic [1:0] o_in);
    start = 1'b1;
    op    = o_in;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
  endtask

  task automatic wait_done(input string name, input int exp_c);
    int got;
    got = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        got = cyc;
        step();
        break;
      end
      step();
    end
    chk(name, got, exp_c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'b00, 1, 0, 1, 0, -1, 2'b00};
    vecs[1] = '{2'b01, 2, 0, 0, 1, -1, 2'b00};
    vecs[2] = '{2'b10, 1, 1, 0, 0, -1, 2'b00};
    vecs[3] = '{2'b11, 8, 1, 0, 1, -1, 2'b00};
    vecs[4] = '{2'b00, 1, 0, 1, 0,  3, 2'b11};

    rst = 1'b1; start = 1'b0; stall = 1'b0; op = 2'b00;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset wb_valid", wb_valid, 0);
    chk("reset sel_0", sel_0, 0);
    chk("reset KD_mode", KD_mode, 0);
    chk("reset sel_1", sel_1, 0);
    chk("reset stage", stage, 0);
    step();

    // Unstalled runs of all four ops, plus an ignored mid-op start.
    for (int v = 0; v < 5; v++) begin
      start_op(vecs[v].op);
      done_c = 1 + 2 * (PAIRS + vecs[v].lat + 1);
      per    = PAIRS + vecs[v].lat + 1;
      for (int c = 1; c <= done_c + 2; c++) begin
        start = (c == vecs[v].restart_at);
        op    = start ? vecs[v].restart_op : vecs[v].op;
        @(negedge clk);
        e_rd = 0; e_ri = 0; e_wb = 0; e_wi = 0; e_st = 0; e_busy = 0; e_done = 0;
        if (c < done_c) begin
          s = (c - 1) / per;
          o = (c - 1) % per;
          e_busy = 1;
          e_st   = s;
          if (o < PAIRS) begin e_rd = 1; e_ri = o; end
          if (o >= vecs[v].lat && o < vecs[v].lat + PAIRS) begin
            e_wb = 1; e_wi = o - vecs[v].lat;
          end
        end else if (c == done_c) begin
          e_done = 1;
        end
        chk($sformatf("v%0d c%0d rd_valid", v, c), rd_valid, e_rd);
        if (e_rd != 0) chk($sformatf("v%0d c%0d rd_idx", v, c), rd_idx, e_ri);
        chk($sformatf("v%0d c%0d wb_valid", v, c), wb_valid, e_wb);
        if (e_wb != 0) chk($sformatf("v%0d c%0d wb_idx", v, c), wb_idx, e_wi);
        chk($sformatf("v%0d c%0d busy", v, c), busy, e_busy);
        chk($sformatf("v%0d c%0d done", v, c), done, e_done);
        if (e_busy != 0) chk($sformatf("v%0d c%0d stage", v, c), stage, e_st);
        if (c == 1 || c == done_c) begin
          chk($sformatf("v%0d c%0d KD_mode", v, c), KD_mode, vecs[v].kd);
          chk($sformatf("v%0d c%0d sel_0", v, c), sel_0, vecs[v].s0);
          chk($sformatf("v%0d c%0d sel_1", v, c), sel_1, vecs[v].s1);
        end
        step();
      end
      start = 1'b0;
    end

    // K-INTT with a 3-cycle stall after the second issue.
    start_op(2'b01);
    nrd = 0; nwb = 0;
    for (int c = 1; c <= 11; c++) begin
      stall = (c >= 3 && c <= 5);
      @(negedge clk);
      if (c <= 10) begin
        if (rd_valid && nrd < 8) begin rdc[nrd] = c; rdi[nrd] = int'(rd_idx); nrd++; end
        if (wb_valid && nwb < 8) begin wbc[nwb] = c; wbi[nwb] = int'(wb_idx); nwb++; end
      end else begin
        chk("stall stage1 rd_valid", rd_valid, 1);
        chk("stall stage1 rd_idx", rd_idx, 0);
        chk("stall stage1 stage", stage, 1);
      end
      step();
    end
    stall = 1'b0;
    chk("stall rd count", nrd, 4);
    chk("stall wb count", nwb, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < nrd) begin
        chk($sformatf("stall rd%0d cycle", k), rdc[k], exp_rdc[k]);
        chk($sformatf("stall rd%0d idx", k), rdi[k], k);
      end
      if (k < nwb) begin
        chk($sformatf("stall wb%0d cycle", k), wbc[k], exp_wbc[k]);
        chk($sformatf("stall wb%0d idx", k), wbi[k], k);
      end
    end
    wait_done("stall done cycle", 18);

    // Reset during stage 1 of D-NTT.
    start_op(2'b10);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 8) begin
        chk("pre-rst stage", stage, 1);
        chk("pre-rst rd_idx", rd_idx, 1);
        rst = 1'b1;
      end
      step();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst busy", busy, 0);
    chk("post-rst rd_valid", rd_valid, 0);
    chk("post-rst wb_valid", wb_valid, 0);
    chk("post-rst KD_mode", KD_mode, 0);
    chk("post-rst sel_0", sel_0, 0);
    chk("post-rst sel_1", sel_1, 0);
    chk("post-rst stage", stage, 0);
    chk("post-rst done", done, 0);
    step();
    n_wb_seen = 0; n_done_seen = 0; n_busy_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      n_wb_seen   += int'(wb_valid);
      n_done_seen += int'(done);
      n_busy_seen += int'(busy);
      step();
    end
    chk("post-rst wb seen", n_wb_seen, 0);
    chk("post-rst done seen", n_done_seen, 0);
    chk("post-rst busy seen", n_busy_seen, 0);
    start_op(2'b00);
    @(negedge clk);
    chk("restart rd_valid", rd_valid, 1);
    chk("restart rd_idx", rd_idx, 0);
    chk("restart sel_0", sel_0, 1);
    step();
    wait_done("restart done cycle", 13);

    // Start in the done cycle is dropped; start in the next cycle is taken.
    start_op(2'b00);
    for (int c = 1; c <= 12; c++) step();
    start = 1'b1;
    op    = 2'b10;
    @(negedge clk);
    chk("b2b done pulse", done, 1);
    step();
    @(negedge clk);
    chk("b2b ignored busy", busy, 0);
    chk("b2b ignored done", done, 0);
    chk("b2b ignored sel_0", sel_0, 1);
    chk("b2b ignored KD_mode", KD_mode, 0);
    op = 2'b01;
    step();
    start = 1'b0;
    cyc   = 1;
    @(negedge clk);
    chk("b2b accepted busy", busy, 1);
    chk("b2b accepted KD_mode", KD_mode, 0);
    chk("b2b accepted sel_0", sel_0, 0);
    chk("b2b accepted sel_1", sel_1, 1);
    chk("b2b accepted rd_valid", rd_valid, 1);
    chk("b2b accepted rd_idx", rd_idx, 0);
    step();
    wait_done("b2b done cycle", 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
